nvdla_dbb_bridge: RTL and testbench

Bridge between the NVDLA core's AXI-like data-backbone (DBB) port and the HWPE streamer. It accepts DBB read/write requests from the core and programs the HWPE source/sink streamers (`ctrl_streamer_o`). It then moves burst data between the HWPE streams (`dbb_i` / `dbb_o`) and the DBB R/W channels, and generates write responses. It sits inside the NVDLA HWPE engine, between `NV_nvdla` and the streamer.

---
 rtl/nvdla_dbb_bridge_pkg.sv | 121 ++++++++++++
 rtl/nvdla_dbb_bridge_fsm.sv | 186 ++++++++++++++++++
 rtl/nvdla_dbb_bridge.sv | 112 +++++++++++
 tb/tb_nvdla_dbb_bridge.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nvdla_dbb_bridge_pkg.sv
// Shared types for the NVDLA DBB <-> HWPE streamer bridge: DBB channel structs, streamer control, FSM states.
// Latency: none (types, constants and one pure helper function).
// Backpressure: n/a.
package nvdla_package;

   localparam int unsigned NVDLA_DBB_DW = 512;
   localparam int unsigned NVDLA_DBB_AW = 64;
   localparam int unsigned NVDLA_DBB_IW = 8;
   localparam int unsigned NVDLA_DBB_LW = 4;
   localparam int unsigned NVDLA_DBB_SW = NVDLA_DBB_DW / 8;

   typedef enum logic [2:0] {
      DBB_IDLE, DBB_RD_START, DBB_RD_DATA, DBB_WR_START, DBB_WR_DATA, DBB_WR_RESP
   } dbb_state_e;

   // Core -> bridge channel halves
   typedef struct packed {
      logic                    valid;
      logic [NVDLA_DBB_AW-1:0] addr;
      logic [NVDLA_DBB_IW-1:0] id;
      logic [NVDLA_DBB_LW-1:0] len;
   } aw_request_ctrl_t;
   typedef aw_request_ctrl_t ar_request_ctrl_t;

   typedef struct packed {
      logic                    valid;
      logic [NVDLA_DBB_DW-1:0] data;
      logic [NVDLA_DBB_SW-1:0] strb;
      logic                    last;
   } w_data_ctrl_t;

   typedef struct packed { logic ready; } b_response_ctrl_t;
   typedef struct packed { logic ready; } r_data_ctrl_t;

   typedef struct packed {
      aw_request_ctrl_t aw;
      w_data_ctrl_t     w;
      b_response_ctrl_t b;
      ar_request_ctrl_t ar;
      r_data_ctrl_t     r;
   } ctrl_dbb_t;

   // Bridge -> core channel halves
   typedef struct packed { logic ready; } aw_request_flags_t;
   typedef struct packed { logic ready; } ar_request_flags_t;
   typedef struct packed { logic ready; } w_data_flags_t;

   typedef struct packed {
      logic                    valid;
      logic [NVDLA_DBB_IW-1:0] id;
   } b_response_flags_t;

   typedef struct packed {
      logic                    valid;
      logic [NVDLA_DBB_IW-1:0] id;
      logic                    last;
      logic [NVDLA_DBB_DW-1:0] data;
   } r_data_flags_t;

   typedef struct packed {
      aw_request_flags_t aw;
      w_data_flags_t     w;
      b_response_flags_t b;
      ar_request_flags_t ar;
      r_data_flags_t     r;
   } flags_dbb_t;

   // Streamer address generator programming
   typedef struct packed {
      logic [31:0] base_addr;
      logic [31:0] trans_size;
      logic [15:0] line_stride;
      logic [15:0] line_length;
      logic [15:0] feat_stride;
      logic [15:0] feat_length;
      logic        loop_outer;
      logic        realign_type;
   } addressgen_ctrl_t;

   typedef struct packed {
      logic             req_start;
      addressgen_ctrl_t addressgen_ctrl;
   } streamer_ctrl_t;

   typedef struct packed {
      streamer_ctrl_t source;
      streamer_ctrl_t sink;
   } ctrl_dbb_streamer_t;

   typedef struct packed {
      logic ready_start;
      logic done;
   } streamer_flags_t;

   typedef struct packed {
      streamer_flags_t source;
      streamer_flags_t sink;
   } flags_dbb_streamer_t;

   // HWPE stream beat (valid + payload; ready travels separately)
   typedef struct packed {
      logic                    valid;
      logic [NVDLA_DBB_DW-1:0] data;
      logic [NVDLA_DBB_SW-1:0] strb;
   } dbb_stream_t;

   // One linear line of len+1 beats starting at base
   function automatic addressgen_ctrl_t agen_cfg(input logic [31:0] base,
                                                 input logic [NVDLA_DBB_LW-1:0] len,
                                                 input logic [15:0] stride);
      addressgen_ctrl_t c;
      c             = '0;
      c.base_addr   = base;
      c.trans_size  = 32'(len) + 32'd1;
      c.line_stride = stride;
      c.line_length = 16'(len) + 16'd1;
      c.feat_length = 16'd1;
      return c;
   endfunction

endpackage

// File: rtl/nvdla_dbb_bridge_fsm.sv
// Transaction FSM for the DBB bridge: request latching, streamer start, beat counting, write response (trace macro NVDLA_DBB_TRACE_EN).
// Latency: req_start earliest the cycle after aw/ar handshake; b.valid the cycle after last W beat and sink done.
// Backpressure: waits on ready_start, on R/W handshakes from the top, and holds b.valid until b.ready.
module nvdla_dbb_fsm
   import nvdla_package::*;
#(
   parameter int unsigned ID_WIDTH  = NVDLA_DBB_IW,
   parameter int unsigned LEN_WIDTH = NVDLA_DBB_LW
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 aw_vld_i,
   input  logic [31:0]          aw_addr_i,
   input  logic [ID_WIDTH-1:0]  aw_id_i,
   input  logic [LEN_WIDTH-1:0] aw_len_i,
   input  logic                 ar_vld_i,
   input  logic [31:0]          ar_addr_i,
   input  logic [ID_WIDTH-1:0]  ar_id_i,
   input  logic [LEN_WIDTH-1:0] ar_len_i,
   input  logic                 r_hs_i,
   input  logic                 w_hs_i,
   input  logic                 src_ready_start_i,
   input  logic                 snk_ready_start_i,
   input  logic                 snk_done_i,
   input  logic                 b_rdy_i,
   output dbb_state_e           state_o,
   output logic                 last_o,
   output logic [31:0]          addr_o,
   output logic [ID_WIDTH-1:0]  id_o,
   output logic [LEN_WIDTH-1:0] len_o,
   output logic                 b_vld_o,
   output logic                 aw_rdy_o,
   output logic                 ar_rdy_o,
   output logic                 src_start_o,
   output logic                 snk_start_o
);

   dbb_state_e           state_q, state_d;
   logic [LEN_WIDTH:0]   cnt_q, cnt_d;
   logic [31:0]          addr_q, addr_d;
   logic [ID_WIDTH-1:0]  id_q, id_d;
   logic [LEN_WIDTH-1:0] len_q, len_d;
   logic                 done_q, done_d;
   logic                 b_vld_q, b_vld_d;
   logic                 arm_q, arm_d;
   logic                 last_beat;

   // arm_q keeps the request readies low for the first cycle after reset/clear
   assign aw_rdy_o  = (state_q == DBB_IDLE) && arm_q && !clear_i;
   assign ar_rdy_o  = aw_rdy_o && !aw_vld_i;
   assign last_beat = (cnt_q == {1'b0, len_q});

   // Next-state, beat counting, request latching and streamer start pulses
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      id_d        = id_q;
      len_d       = len_q;
      done_d      = done_q;
      b_vld_d     = b_vld_q;
      arm_d       = 1'b1;
      src_start_o = 1'b0;
      snk_start_o = 1'b0;
      case (state_q)
         DBB_IDLE: begin
            cnt_d  = '0;
            done_d = 1'b0;
            if (aw_vld_i && aw_rdy_o) begin
               addr_d  = aw_addr_i;
               id_d    = aw_id_i;
               len_d   = aw_len_i;
               state_d = DBB_WR_START;
            end else if (ar_vld_i && ar_rdy_o) begin
               addr_d  = ar_addr_i;
               id_d    = ar_id_i;
               len_d   = ar_len_i;
               state_d = DBB_RD_START;
            end
         end
         DBB_RD_START: begin
            if (src_ready_start_i) begin
               src_start_o = 1'b1;
               state_d     = DBB_RD_DATA;
            end
         end
         DBB_RD_DATA: begin
            if (r_hs_i) begin
               if (last_beat) begin
                  cnt_d   = '0;
                  state_d = DBB_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         DBB_WR_START: begin
            if (snk_done_i) done_d = 1'b1;
            if (snk_ready_start_i) begin
               snk_start_o = 1'b1;
               state_d     = DBB_WR_DATA;
            end
         end
         DBB_WR_DATA: begin
            if (snk_done_i) done_d = 1'b1;
            if (w_hs_i) begin
               if (last_beat) begin
                  cnt_d   = '0;
                  b_vld_d = done_q || snk_done_i;
                  state_d = DBB_WR_RESP;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         DBB_WR_RESP: begin
            if (!b_vld_q && (done_q || snk_done_i)) begin
               b_vld_d = 1'b1;
            end
            if (b_vld_q && b_rdy_i) begin
               b_vld_d = 1'b0;
               done_d  = 1'b0;
               state_d = DBB_IDLE;
            end
         end
         default: state_d = DBB_IDLE;
      endcase
      if (clear_i) begin
         state_d     = DBB_IDLE;
         cnt_d       = '0;
         addr_d      = '0;
         id_d        = '0;
         len_d       = '0;
         done_d      = 1'b0;
         b_vld_d     = 1'b0;
         arm_d       = 1'b0;
         src_start_o = 1'b0;
         snk_start_o = 1'b0;
      end
   end

   // State and transaction registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= DBB_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         id_q    <= '0;
         len_q   <= '0;
         done_q  <= 1'b0;
         b_vld_q <= 1'b0;
         arm_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         id_q    <= id_d;
         len_q   <= len_d;
         done_q  <= done_d;
         b_vld_q <= b_vld_d;
         arm_q   <= arm_d;
      end
   end

`ifdef NVDLA_DBB_TRACE_EN
   // Simulation trace of accepted requests and write responses
   always_ff @(posedge clk_i) begin
      if (rst_ni && aw_vld_i && aw_rdy_o)
         $display("[NVDLA] DBB WR addr=0x%08h id=0x%0h len=%0d", aw_addr_i, aw_id_i, aw_len_i);
      if (rst_ni && ar_vld_i && ar_rdy_o)
         $display("[NVDLA] DBB RD addr=0x%08h id=0x%0h len=%0d", ar_addr_i, ar_id_i, ar_len_i);
      if (rst_ni && b_vld_q && b_rdy_i)
         $display("[NVDLA] DBB B id=0x%0h", id_q);
   end
`else
`endif

   assign state_o = state_q;
   assign last_o  = last_beat;
   assign addr_o  = addr_q;
   assign id_o    = id_q;
   assign len_o   = len_q;
   assign b_vld_o = b_vld_q;

endmodule

// File: rtl/nvdla_dbb_bridge.sv
// DBB <-> HWPE streamer bridge top: programs streamers and steers R/W beats (trace macro NVDLA_DBB_TRACE_EN, in the FSM).
// Latency: R/W beats pass combinationally; one transaction in flight at a time.
// Backpressure: r.ready drives dbb_i ready, dbb_o ready drives w.ready; aw/ar ready only while idle.
module nvdla_dbb_bridge
   import nvdla_package::*;
#(
   parameter int unsigned DATA_WIDTH = NVDLA_DBB_DW,
   parameter int unsigned ADDR_WIDTH = NVDLA_DBB_AW,
   parameter int unsigned ID_WIDTH   = NVDLA_DBB_IW,
   parameter int unsigned LEN_WIDTH  = NVDLA_DBB_LW
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                test_mode_i,
   input  logic                clear_i,
   output ctrl_dbb_streamer_t  ctrl_streamer_o,
   input  flags_dbb_streamer_t flags_streamer_i,
   input  ctrl_dbb_t           ctrl_i,
   output flags_dbb_t          flags_o,
   input  dbb_stream_t         dbb_i,
   output logic                dbb_i_rdy_o,
   output dbb_stream_t         dbb_o,
   input  logic                dbb_o_rdy_i
);

   dbb_state_e           state;
   logic                 last;
   logic [31:0]          addr_q;
   logic [ID_WIDTH-1:0]  id_q;
   logic [LEN_WIDTH-1:0] len_q;
   logic                 b_vld, aw_rdy, ar_rdy, src_start, snk_start;
   logic                 rd_data, wr_data, r_hs, w_hs;
   addressgen_ctrl_t     agen;
   logic                 unused_bits;

   assign rd_data = (state == DBB_RD_DATA);
   assign wr_data = (state == DBB_WR_DATA);
   assign r_hs    = rd_data && dbb_i.valid && ctrl_i.r.ready;
   assign w_hs    = wr_data && ctrl_i.w.valid && dbb_o_rdy_i;
   assign agen    = agen_cfg(addr_q, len_q, 16'(DATA_WIDTH / 8));

   // Upper address bits, input strobe, w.last and source done carry no control meaning here
   assign unused_bits = ^{test_mode_i, ctrl_i.w.last, ctrl_i.aw.addr[ADDR_WIDTH-1:32],
                          ctrl_i.ar.addr[ADDR_WIDTH-1:32], dbb_i.strb, flags_streamer_i.source.done};

   nvdla_dbb_fsm #(
      .ID_WIDTH  (ID_WIDTH),
      .LEN_WIDTH (LEN_WIDTH)
   ) i_fsm (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .clear_i           (clear_i),
      .aw_vld_i          (ctrl_i.aw.valid),
      .aw_addr_i         (ctrl_i.aw.addr[31:0]),
      .aw_id_i           (ctrl_i.aw.id),
      .aw_len_i          (ctrl_i.aw.len),
      .ar_vld_i          (ctrl_i.ar.valid),
      .ar_addr_i         (ctrl_i.ar.addr[31:0]),
      .ar_id_i           (ctrl_i.ar.id),
      .ar_len_i          (ctrl_i.ar.len),
      .r_hs_i            (r_hs),
      .w_hs_i            (w_hs),
      .src_ready_start_i (flags_streamer_i.source.ready_start),
      .snk_ready_start_i (flags_streamer_i.sink.ready_start),
      .snk_done_i        (flags_streamer_i.sink.done),
      .b_rdy_i           (ctrl_i.b.ready),
      .state_o           (state),
      .last_o            (last),
      .addr_o            (addr_q),
      .id_o              (id_q),
      .len_o             (len_q),
      .b_vld_o           (b_vld),
      .aw_rdy_o          (aw_rdy),
      .ar_rdy_o          (ar_rdy),
      .src_start_o       (src_start),
      .snk_start_o       (snk_start)
   );

   // Channel steering between the core's DBB port and the streams, gated by transaction phase
   always_comb begin
      flags_o         = '0;
      ctrl_streamer_o = '0;
      dbb_o           = '0;
      dbb_i_rdy_o     = 1'b0;
      flags_o.aw.ready = aw_rdy;
      flags_o.ar.ready = ar_rdy;
      flags_o.b.valid  = b_vld;
      flags_o.b.id     = id_q;
      flags_o.r.id     = id_q;
      ctrl_streamer_o.source.req_start = src_start;
      ctrl_streamer_o.sink.req_start   = snk_start;
      if (state == DBB_RD_START || rd_data) begin
         ctrl_streamer_o.source.addressgen_ctrl = agen;
      end
      if (state == DBB_WR_START || wr_data || state == DBB_WR_RESP) begin
         ctrl_streamer_o.sink.addressgen_ctrl = agen;
      end
      if (rd_data) begin
         flags_o.r.valid = dbb_i.valid;
         flags_o.r.data  = dbb_i.data;
         flags_o.r.last  = last;
         dbb_i_rdy_o     = ctrl_i.r.ready;
      end
      if (wr_data) begin
         dbb_o.valid     = ctrl_i.w.valid;
         dbb_o.data      = ctrl_i.w.data;
         dbb_o.strb      = ctrl_i.w.strb;
         flags_o.w.ready = dbb_o_rdy_i;
      end
   end

endmodule

// File: tb/tb_nvdla_dbb_bridge.sv
// Directed bench for nvdla_dbb_bridge: read/write bursts, aw/ar priority, backpressure, start stall, clear.
// Latency: checks taken mid-cycle after inputs settle; handshakes occur on the following rising edge.
// Backpressure: bench toggles r.ready and dbb_o ready and tracks accepted beats itself.
module tb_nvdla_dbb_bridge;
   import nvdla_package::*;

   logic                clk_i = 1'b0;
   logic                rst_ni, test_mode_i, clear_i;
   ctrl_dbb_streamer_t  ctrl_streamer_o;
   flags_dbb_streamer_t flags_streamer_i;
   ctrl_dbb_t           ctrl_i;
   flags_dbb_t          flags_o;
   dbb_stream_t         dbb_i, dbb_o;
   logic                dbb_i_rdy_o, dbb_o_rdy_i;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_i = ~clk_i;

   nvdla_dbb_bridge dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .test_mode_i      (test_mode_i),
      .clear_i          (clear_i),
      .ctrl_streamer_o  (ctrl_streamer_o),
      .flags_streamer_i (flags_streamer_i),
      .ctrl_i           (ctrl_i),
      .flags_o          (flags_o),
      .dbb_i            (dbb_i),
      .dbb_i_rdy_o      (dbb_i_rdy_o),
      .dbb_o            (dbb_o),
      .dbb_o_rdy_i      (dbb_o_rdy_i)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic issue_ar(input logic [63:0] addr, input logic [7:0] id, input logic [3:0] len);
      ctrl_i.ar.valid = 1'b1;
      ctrl_i.ar.addr  = addr;
      ctrl_i.ar.id    = id;
      ctrl_i.ar.len   = len;
      #1;
      chk("ar_ready", flags_o.ar.ready, 1);
      tick;
      ctrl_i.ar.valid = 1'b0;
      #1;
   endtask

   task automatic issue_aw(input logic [63:0] addr, input logic [7:0] id, input logic [3:0] len);
      ctrl_i.aw.valid = 1'b1;
      ctrl_i.aw.addr  = addr;
      ctrl_i.aw.id    = id;
      ctrl_i.aw.len   = len;
      #1;
      chk("aw_ready", flags_o.aw.ready, 1);
      tick;
      ctrl_i.aw.valid = 1'b0;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int beat;
      rst_ni = 1'b0; clear_i = 1'b0; test_mode_i = 1'b0;
      ctrl_i = '0; flags_streamer_i = '0; dbb_i = '0; dbb_o_rdy_i = 1'b0;
      #12;
      chk("rst_flags_zero", flags_o == '0, 1);
      chk("rst_streamer_zero", ctrl_streamer_o == '0, 1);
      chk("rst_dbb_o_zero", dbb_o == '0, 1);
      chk("rst_dbb_i_rdy", dbb_i_rdy_o, 0);
      @(negedge clk_i) rst_ni = 1'b1;
      flags_streamer_i.source.ready_start = 1'b1;
      flags_streamer_i.sink.ready_start   = 1'b1;
      tick;
      chk("idle_aw_ready", flags_o.aw.ready, 1);

      // ---- read burst: addr 0x1000_0040, id 3, len 3
      issue_ar(64'h1000_0040, 8'd3, 4'd3);
      chk("rd_req_start", ctrl_streamer_o.source.req_start, 1);
      chk("rd_snk_no_start", ctrl_streamer_o.sink.req_start, 0);
      chk("rd_base_addr", ctrl_streamer_o.source.addressgen_ctrl.base_addr, 64'h1000_0040);
      chk("rd_trans_size", ctrl_streamer_o.source.addressgen_ctrl.trans_size, 4);
      chk("rd_line_length", ctrl_streamer_o.source.addressgen_ctrl.line_length, 4);
      chk("rd_line_stride", ctrl_streamer_o.source.addressgen_ctrl.line_stride, 64);
      chk("rd_feat_length", ctrl_streamer_o.source.addressgen_ctrl.feat_length, 1);
      chk("rd_aw_busy", flags_o.aw.ready, 0);
      tick;
      chk("rd_start_one_cycle", ctrl_streamer_o.source.req_start, 0);
      ctrl_i.r.ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         dbb_i.valid = 1'b1;
         dbb_i.data  = '0;
         dbb_i.data[63:0] = 64'hD000 + 64'(i);
         #1;
         chk("rd_r_valid", flags_o.r.valid, 1);
         chk("rd_r_id", flags_o.r.id, 3);
         chk("rd_r_last", flags_o.r.last, (i == 3));
         chk("rd_r_data", flags_o.r.data[63:0], 64'hD000 + 64'(i));
         chk("rd_dbb_i_rdy", dbb_i_rdy_o, 1);
         tick;
      end
      dbb_i.valid = 1'b0;
      #1;
      chk("rd_back_idle", flags_o.ar.ready, 1);

      // ---- write burst: addr 0x2000, id 5, len 1
      issue_aw(64'h2000, 8'd5, 4'd1);
      chk("wr_req_start", ctrl_streamer_o.sink.req_start, 1);
      chk("wr_src_no_start", ctrl_streamer_o.source.req_start, 0);
      chk("wr_base_addr", ctrl_streamer_o.sink.addressgen_ctrl.base_addr, 64'h2000);
      chk("wr_trans_size", ctrl_streamer_o.sink.addressgen_ctrl.trans_size, 2);
      tick;
      dbb_o_rdy_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         ctrl_i.w.valid = 1'b1;
         ctrl_i.w.strb  = '1;
         ctrl_i.w.data  = '0;
         ctrl_i.w.data[63:0] = 64'hA100 + 64'(i);
         #1;
         chk("wr_dbb_o_valid", dbb_o.valid, 1);
         chk("wr_dbb_o_data", dbb_o.data[63:0], 64'hA100 + 64'(i));
         chk("wr_dbb_o_strb", dbb_o.strb, 64'hFFFF_FFFF_FFFF_FFFF);
         chk("wr_w_ready", flags_o.w.ready, 1);
         tick;
      end
      ctrl_i.w.valid = 1'b0;
      #1;
      chk("wr_b_wait_done", flags_o.b.valid, 0);
      chk("wr_dbb_o_idle", dbb_o.valid, 0);
      flags_streamer_i.sink.done = 1'b1;
      #1;
      chk("wr_b_not_same_cycle", flags_o.b.valid, 0);
      tick;
      flags_streamer_i.sink.done = 1'b0;
      #1;
      chk("wr_b_valid", flags_o.b.valid, 1);
      chk("wr_b_id", flags_o.b.id, 5);
      tick;
      chk("wr_b_hold", flags_o.b.valid, 1);
      ctrl_i.b.ready = 1'b1;
      #1;
      tick;
      ctrl_i.b.ready = 1'b0;
      #1;
      chk("wr_b_drop", flags_o.b.valid, 0);
      chk("wr_back_idle", flags_o.aw.ready, 1);

      // ---- simultaneous aw (id 7) and ar (id 9): write first
      ctrl_i.aw.valid = 1'b1; ctrl_i.aw.addr = 64'h3000; ctrl_i.aw.id = 8'd7; ctrl_i.aw.len = 4'd0;
      ctrl_i.ar.valid = 1'b1; ctrl_i.ar.addr = 64'h4000; ctrl_i.ar.id = 8'd9; ctrl_i.ar.len = 4'd0;
      #1;
      chk("both_aw_ready", flags_o.aw.ready, 1);
      chk("both_ar_held", flags_o.ar.ready, 0);
      tick;
      ctrl_i.aw.valid = 1'b0;
      #1;
      chk("both_wr_start", ctrl_streamer_o.sink.req_start, 1);
      chk("both_no_rd_start", ctrl_streamer_o.source.req_start, 0);
      tick;
      ctrl_i.w.valid = 1'b1;
      flags_streamer_i.sink.done = 1'b1;
      #1;
      chk("both_ar_busy", flags_o.ar.ready, 0);
      tick;
      ctrl_i.w.valid = 1'b0;
      flags_streamer_i.sink.done = 1'b0;
      #1;
      chk("both_b_valid", flags_o.b.valid, 1);
      chk("both_b_id", flags_o.b.id, 7);
      chk("both_ar_wait_b", flags_o.ar.ready, 0);
      ctrl_i.b.ready = 1'b1;
      #1;
      tick;
      ctrl_i.b.ready = 1'b0;
      #1;
      chk("both_ar_now_ready", flags_o.ar.ready, 1);
      tick;
      ctrl_i.ar.valid = 1'b0;
      #1;
      chk("both_rd_start", ctrl_streamer_o.source.req_start, 1);
      chk("both_rd_base", ctrl_streamer_o.source.addressgen_ctrl.base_addr, 64'h4000);
      tick;
      dbb_i.valid = 1'b1;
      #1;
      chk("both_r_last", flags_o.r.last, 1);
      chk("both_r_id", flags_o.r.id, 9);
      tick;
      dbb_i.valid = 1'b0;

      // ---- backpressure on R: r.ready toggles every cycle, len 3
      issue_ar(64'h5000, 8'd2, 4'd3);
      tick;
      beat = 0;
      dbb_i.valid = 1'b1;
      for (int c = 0; c < 20 && beat < 4; c++) begin
         ctrl_i.r.ready = (c % 2 == 0);
         dbb_i.data[63:0] = 64'hB000 + 64'(beat);
         #1;
         chk("bp_r_valid", flags_o.r.valid, 1);
         chk("bp_r_last", flags_o.r.last, (beat == 3));
         chk("bp_r_rdy_map", dbb_i_rdy_o, ctrl_i.r.ready);
         if (ctrl_i.r.ready) beat++;
         tick;
      end
      dbb_i.valid = 1'b0;
      ctrl_i.r.ready = 1'b1;
      #1;
      chk("bp_r_beats", beat, 4);
      chk("bp_r_idle", flags_o.ar.ready, 1);

      // ---- backpressure on W: dbb_o ready toggles, len 2, done arrives early
      issue_aw(64'h6000, 8'd4, 4'd2);
      flags_streamer_i.sink.done = 1'b1;
      #1;
      tick;
      flags_streamer_i.sink.done = 1'b0;
      beat = 0;
      ctrl_i.w.valid = 1'b1;
      for (int c = 0; c < 20 && beat < 3; c++) begin
         dbb_o_rdy_i = (c % 2 == 1);
         ctrl_i.w.data[63:0] = 64'hC000 + 64'(beat);
         #1;
         chk("bp_w_valid", dbb_o.valid, 1);
         chk("bp_w_data", dbb_o.data[63:0], 64'hC000 + 64'(beat));
         chk("bp_w_rdy_map", flags_o.w.ready, dbb_o_rdy_i);
         if (dbb_o_rdy_i) beat++;
         tick;
      end
      ctrl_i.w.valid = 1'b0;
      #1;
      chk("bp_w_beats", beat, 3);
      chk("bp_w_b_early_done", flags_o.b.valid, 1);
      chk("bp_w_b_id", flags_o.b.id, 4);
      ctrl_i.b.ready = 1'b1;
      #1;
      tick;
      ctrl_i.b.ready = 1'b0;
      #1;
      chk("bp_w_idle", flags_o.aw.ready, 1);

      // ---- ready_start low for 5 cycles after ar handshake
      flags_streamer_i.source.ready_start = 1'b0;
      issue_ar(64'h7000, 8'd1, 4'd0);
      for (int k = 0; k < 5; k++) begin
         chk("rs_no_start", ctrl_streamer_o.source.req_start, 0);
         tick;
      end
      flags_streamer_i.source.ready_start = 1'b1;
      #1;
      chk("rs_start", ctrl_streamer_o.source.req_start, 1);
      chk("rs_base", ctrl_streamer_o.source.addressgen_ctrl.base_addr, 64'h7000);
      tick;
      chk("rs_start_once", ctrl_streamer_o.source.req_start, 0);
      dbb_i.valid = 1'b1;
      #1;
      chk("rs_r_last", flags_o.r.last, 1);
      tick;
      dbb_i.valid = 1'b0;

      // ---- clear during RD_DATA after 1 of 4 beats
      issue_ar(64'h8000, 8'd6, 4'd3);
      tick;
      dbb_i.valid = 1'b1;
      #1;
      chk("clr_first_not_last", flags_o.r.last, 0);
      tick;
      dbb_i.valid = 1'b0;
      clear_i = 1'b1;
      #1;
      tick;
      clear_i = 1'b0;
      #1;
      chk("clr_flags_zero", flags_o == '0, 1);
      chk("clr_streamer_zero", ctrl_streamer_o == '0, 1);
      chk("clr_dbb_o_zero", dbb_o == '0, 1);
      chk("clr_dbb_i_rdy", dbb_i_rdy_o, 0);
      tick;
      issue_ar(64'h9000, 8'd8, 4'd1);
      chk("clr_new_start", ctrl_streamer_o.source.req_start, 1);
      chk("clr_new_base", ctrl_streamer_o.source.addressgen_ctrl.base_addr, 64'h9000);
      chk("clr_new_size", ctrl_streamer_o.source.addressgen_ctrl.trans_size, 2);
      tick;
      dbb_i.valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("clr_new_last", flags_o.r.last, (i == 1));
         chk("clr_new_id", flags_o.r.id, 8);
         tick;
      end
      dbb_i.valid = 1'b0;
      #1;
      chk("clr_new_idle", flags_o.ar.ready, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
